// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

  localparam int SERIAL_SUB_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// Single-bit subtractor cell: d = x - y - bi, bo = borrow out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first, one result per WIDTH RUN cycles.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SERIAL_SUB_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, next_state;
  logic [WIDTH-1:0] a_sh, b_sh, res;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             d_bit, bo_bit;
  logic             last;

  assign last = (cnt == LAST);

  full_subtractor u_cell (
    .x  (a_sh[0]),
    .y  (b_sh[0]),
    .bi (br),
    .d  (d_bit),
    .bo (bo_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid) next_state = RUN;
      RUN:     if (last)     next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Result bits enter from the MSB side so bit 0 lands at the LSB after WIDTH shifts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh <= '0;
      b_sh <= '0;
      res  <= '0;
      br   <= 1'b0;
      cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh <= a;
            b_sh <= b;
            br   <= bin;
            cnt  <= '0;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          res  <= {d_bit, res[WIDTH-1:1]};
          br   <= bo_bit;
          if (!last) cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign diff      = res;
  assign bout      = br;

`ifdef SERIAL_SUB_OVF_EN
  // The borrow out of the MSB stays in br, so only the MSB borrow-in needs saving.
  logic msb_bin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     msb_bin <= 1'b0;
    else if (state == RUN && last)  msb_bin <= br;
  end

  assign ovf = msb_bin ^ br;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic             bin = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one operand set and wait for the accept edge; returns 1 time unit after it.
  task automatic applyStimulus(input string tag, input logic [7:0] av, input logic [7:0] bv,
                               input logic bv_in);
    int waited = 0;
    while (in_ready !== 1'b1 && waited < 4 * WIDTH) begin
      @(posedge clk); #1;
      waited++;
    end
    checkOutput({tag, "_idle_ready"}, in_ready, 1'b1);
    a = av;
    b = bv;
    bin = bv_in;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput({tag, "_accepted"}, in_ready, 1'b0);
  endtask

  // Wait for the result, check it, optionally stall, then complete the output handshake.
  task automatic waitResult(input string tag, input logic [7:0] ed, input logic eb,
                            input logic eo, input int hold, input bit offer);
    int cycles = 0;
    string id;
    id = $sformatf("%s(ovf=%0b)", tag, eo);
    while (out_valid !== 1'b1 && cycles < 4 * WIDTH) begin
      @(posedge clk); #1;
      cycles++;
    end
    checkOutput({id, "_latency"}, cycles, WIDTH);
    checkOutput({id, "_diff"}, diff, ed);
    checkOutput({id, "_bout"}, bout, eb);
`ifdef SERIAL_SUB_OVF_EN
    checkOutput({id, "_ovf"}, ovf, eo);
`endif
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("%s_hold%0d_valid", id, i), out_valid, 1'b1);
      checkOutput($sformatf("%s_hold%0d_ready", id, i), in_ready, 1'b0);
      checkOutput($sformatf("%s_hold%0d_diff", id, i), diff, ed);
      checkOutput($sformatf("%s_hold%0d_bout", id, i), bout, eb);
    end
    out_ready = 1'b1;
    if (offer) in_valid = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput({id, "_back_idle"}, in_ready, 1'b1);
    checkOutput({id, "_valid_drop"}, out_valid, 1'b0);
  endtask

  initial begin
    #2;
    checkOutput("reset_in_ready", in_ready, 1'b1);
    checkOutput("reset_out_valid", out_valid, 1'b0);
    checkOutput("reset_diff", diff, '0);
    checkOutput("reset_bout", bout, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
    checkOutput("reset_ovf", ovf, 1'b0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    applyStimulus("5m3", 8'h05, 8'h03, 1'b0);
    waitResult("5m3", 8'h02, 1'b0, 1'b0, 0, 0);
    applyStimulus("3m5", 8'h03, 8'h05, 1'b0);
    waitResult("3m5", 8'hFE, 1'b1, 1'b0, 0, 0);
    applyStimulus("0m0b1", 8'h00, 8'h00, 1'b1);
    waitResult("0m0b1", 8'hFF, 1'b1, 1'b0, 0, 0);
    applyStimulus("80m1", 8'h80, 8'h01, 1'b0);
    waitResult("80m1", 8'h7F, 1'b0, 1'b1, 0, 0);
    applyStimulus("7Fm FF", 8'h7F, 8'hFF, 1'b0);
    waitResult("7FmFF", 8'h80, 1'b1, 1'b1, 0, 0);
    applyStimulus("10m5b1", 8'h10, 8'h05, 1'b1);
    waitResult("10m5b1", 8'h0A, 1'b0, 1'b0, 0, 0);

    // Operands change during RUN and are offered during the DONE handshake.
    applyStimulus("bp", 8'h44, 8'h11, 1'b0);
    a = 8'h20;
    b = 8'h01;
    bin = 1'b0;
    waitResult("bp", 8'h33, 1'b0, 1'b0, 5, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("bp_next_accept", in_ready, 1'b0);
    waitResult("bp_next", 8'h1F, 1'b0, 1'b0, 0, 0);

    applyStimulus("rst", 8'hAA, 8'h55, 1'b0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", out_valid, 1'b0);
    checkOutput("midrst_in_ready", in_ready, 1'b1);
    checkOutput("midrst_diff", diff, '0);
    checkOutput("midrst_bout", bout, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus("after_rst", 8'h10, 8'h01, 1'b0);
    waitResult("after_rst", 8'h0F, 1'b0, 1'b0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
